// File: rtl/multdiv_stall_ctrl_if.sv
// Pipeline <-> mult/div sequencer bundle: D/X decode inputs,
// unit ready/exception, start pulses, stall/done/exception outputs.
interface multdiv_stall_ctrl_if;
  logic [31:0] DXIR;
  logic        dx_valid;
  logic        flush;
  logic        md_resultRDY;
  logic        md_exception;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        md_done;
  logic        md_exc;
  logic        busy;
`ifdef MULTDIV_PERF_EN
  logic [15:0] perf_stall_cycles;
`endif

  modport master (
    output DXIR,
    output dx_valid,
    output flush,
    output md_resultRDY,
    output md_exception,
    input  ctrl_MULT,
    input  ctrl_DIV,
    input  stall,
    input  md_done,
    input  md_exc,
    input  busy
`ifdef MULTDIV_PERF_EN
    , input perf_stall_cycles
`endif
  );

  modport slave (
    input  DXIR,
    input  dx_valid,
    input  flush,
    input  md_resultRDY,
    input  md_exception,
    output ctrl_MULT,
    output ctrl_DIV,
    output stall,
    output md_done,
    output md_exc,
    output busy
`ifdef MULTDIV_PERF_EN
    , output perf_stall_cycles
`endif
  );
endinterface

// File: rtl/multdiv_stall_ctrl.sv
// Mult/div sequencer: start pulse, pipeline stall until ready/timeout,
// then md_done (+md_exc) for X/M. Ports: clock, reset_n, md (slave).
// Optional MULTDIV_PERF_EN adds md.perf_stall_cycles (saturating).
module multdiv_stall_ctrl #(
  parameter int MAX_CYCLES = 40,
  parameter int CNT_W      = 6
) (
  input logic clock,
  input logic reset_n,
  multdiv_stall_ctrl_if.slave md
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] OP_RTYPE = 5'd0;
  localparam logic [4:0] ALU_MUL  = 5'd6;
  localparam logic [4:0] ALU_DIV  = 5'd7;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MAX_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             excR;
  logic             excNext;

  logic [4:0] opcode;
  logic [4:0] aluOp;
  logic       isMul;
  logic       isDiv;
  logic       isMd;
  logic       idleGo;
  logic       stallInt;
  logic       unusedBits;

  assign opcode = md.DXIR[31:27];
  assign aluOp  = md.DXIR[6:2];

  assign unusedBits = ^{md.DXIR[26:7], md.DXIR[1:0]};

  always_comb begin
    isMul = 1'b0;
    isDiv = 1'b0;
    if (md.dx_valid && !md.flush &&
        opcode == OP_RTYPE) begin
      unique case (1'b1)
        (aluOp == ALU_MUL): isMul = 1'b1;
        (aluOp == ALU_DIV): isDiv = 1'b1;
        default: ;
      endcase
    end
  end

  assign isMd = isMul | isDiv;

  // Decode-driven outputs are gated by reset_n so they
  // drop at once even while D/X still shows a mult/div.
  assign idleGo = reset_n && (state == IDLE);

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    excNext   = excR;
    unique case (state)
      IDLE: begin
        if (isMd) begin
          stateNext = WAIT;
          cntNext   = '0;
          excNext   = 1'b0;
        end
      end
      WAIT: begin
        if (cnt != CNT_LAST)
          cntNext = cnt + 1'b1;
        // Ready beats timeout when both land together.
        if (md.md_resultRDY) begin
          stateNext = DONE;
          excNext   = md.md_exception;
        end else if (cnt == CNT_LAST) begin
          stateNext = DONE;
          excNext   = 1'b1;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      excR  <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      excR  <= excNext;
    end
  end

  assign stallInt = (idleGo && isMd) ||
                    (state == WAIT);

  always_comb begin
    md.ctrl_MULT = idleGo && isMul;
    md.ctrl_DIV  = idleGo && isDiv;
    md.stall     = stallInt;
    md.md_done   = (state == DONE);
    md.md_exc    = (state == DONE) && excR;
    md.busy      = (state != IDLE);
  end

`ifdef MULTDIV_PERF_EN
  logic [15:0] perfCnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      perfCnt <= '0;
    else if (stallInt && perfCnt != 16'hFFFF)
      perfCnt <= perfCnt + 16'd1;
  end

  assign md.perf_stall_cycles = perfCnt;
`endif

  aOneHot: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(md.ctrl_MULT && md.ctrl_DIV));

  aExcDone: assert property (
    @(posedge clock) disable iff (!reset_n)
    md.md_exc |-> md.md_done);

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Randomized scoreboard bench for multdiv_stall_ctrl:
// driver queues expected completions, monitor checks them.
module tb_multdiv_stall_ctrl;

  localparam int MAXC = 40;

  logic clock;
  logic reset_n;

  multdiv_stall_ctrl_if mdIf ();

  multdiv_stall_ctrl #(
    .MAX_CYCLES(MAXC),
    .CNT_W(6)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .md(mdIf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit div;
    int lat;
    bit exc;
    int stl;
  } exp_t;

  exp_t expQ[$];
  int   checks;
  int   failures;

  bit   inTxn;
  int   cnt;
  int   stallCnt;
  logic start;
  exp_t e;

  task automatic chk(string name,
                     logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  task automatic fail(string name, int act);
    checks++;
    failures++;
    $display("FAIL %s: observed %0d, expected none",
             name, act);
  endtask

  function automatic logic [31:0] mkInst(
      logic [4:0] opc, logic [4:0] alu);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = opc;
    r[6:2] = alu;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    mdIf.dx_valid     = 1'b0;
    mdIf.flush        = 1'b0;
    mdIf.md_resultRDY = 1'b0;
    mdIf.md_exception = 1'b0;
    mdIf.DXIR         = $urandom;
  endtask

  // d = WAIT cycle on which the unit reports ready.
  task automatic doMd(bit div, int d, bit ex);
    int   eff;
    exp_t x;
    eff   = (d <= MAXC) ? d : MAXC;
    x.div = div;
    x.lat = eff + 1;
    x.exc = (d <= MAXC) ? ex : 1'b1;
    x.stl = eff + 1;
    expQ.push_back(x);
    mdIf.DXIR         = mkInst(5'd0, div ? 5'd7 : 5'd6);
    mdIf.dx_valid     = 1'b1;
    mdIf.flush        = 1'b0;
    mdIf.md_resultRDY = 1'($urandom_range(0, 1));
    mdIf.md_exception = 1'($urandom_range(0, 1));
    for (int j = 1; j <= eff + 1; j++) begin
      cyc();
      mdIf.flush        = 1'($urandom_range(0, 1));
      mdIf.md_resultRDY = (j == d);
      mdIf.md_exception = (j == d) ? ex :
                          1'($urandom_range(0, 1));
    end
    cyc();
    idle();
  endtask

  task automatic bubble(int kind);
    logic [4:0] alu;
    unique case (kind)
      0: begin
        mdIf.DXIR     = mkInst(5'd0, 5'd6);
        mdIf.dx_valid = 1'b1;
        mdIf.flush    = 1'b1;
      end
      1: begin
        mdIf.DXIR     = mkInst(5'd0, 5'd7);
        mdIf.dx_valid = 1'b0;
        mdIf.flush    = 1'b0;
      end
      2: begin
        mdIf.DXIR     = mkInst(5'($urandom_range(1, 31)),
                               5'($urandom_range(6, 7)));
        mdIf.dx_valid = 1'b1;
        mdIf.flush    = 1'b0;
      end
      default: begin
        alu = 5'($urandom_range(0, 31));
        if (alu == 5'd6 || alu == 5'd7) alu = 5'd8;
        mdIf.DXIR     = mkInst(5'd0, alu);
        mdIf.dx_valid = 1'b1;
        mdIf.flush    = 1'b0;
      end
    endcase
    mdIf.md_resultRDY = 1'($urandom_range(0, 1));
    #2;
    chk("bubble_stall", mdIf.stall, 0);
    cyc();
    idle();
  endtask

  task automatic resetMidOp();
    exp_t x;
    x.div = 1'b0;
    x.lat = 0;
    x.exc = 1'b0;
    x.stl = 0;
    expQ.push_back(x);
    mdIf.DXIR     = mkInst(5'd0, 5'd6);
    mdIf.dx_valid = 1'b1;
    repeat (7) cyc();
    #2;
    reset_n = 1'b0;
    expQ.delete();
    #1;
    chk("rst_stall", mdIf.stall, 0);
    chk("rst_mult", mdIf.ctrl_MULT, 0);
    chk("rst_div", mdIf.ctrl_DIV, 0);
    chk("rst_done", mdIf.md_done, 0);
    chk("rst_exc", mdIf.md_exc, 0);
    chk("rst_busy", mdIf.busy, 0);
    cyc();
    reset_n = 1'b1;
    idle();
    repeat (2) cyc();
    mdIf.md_resultRDY = 1'b1;
    mdIf.md_exception = 1'b1;
    repeat (2) cyc();
    chk("late_rdy_done", mdIf.md_done, 0);
    chk("late_rdy_busy", mdIf.busy, 0);
    idle();
    cyc();
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      inTxn = 1'b0;
    end else begin
      start = mdIf.ctrl_MULT | mdIf.ctrl_DIV;
      chk("ctrl_onehot",
          mdIf.ctrl_MULT & mdIf.ctrl_DIV, 0);
      if (inTxn) cnt++;
      if (start) begin
        if (inTxn) fail("start_while_busy", cnt);
        if (expQ.size() == 0)
          fail("spurious_start", 1);
        else
          chk("start_kind", mdIf.ctrl_DIV, expQ[0].div);
        inTxn    = 1'b1;
        cnt      = 0;
        stallCnt = 0;
      end
      chk("busy", mdIf.busy, inTxn && !start);
      if (inTxn) stallCnt += int'(mdIf.stall);
      else chk("stall_idle", mdIf.stall, 0);
      if (mdIf.md_done) begin
        if (!inTxn || start || expQ.size() == 0) begin
          fail("spurious_done", cnt);
        end else begin
          e = expQ.pop_front();
          chk("latency", cnt, e.lat);
          chk("md_exc", mdIf.md_exc, e.exc);
          chk("stall_cycles", stallCnt, e.stl);
          inTxn = 1'b0;
        end
      end else begin
        chk("exc_no_done", mdIf.md_exc, 0);
      end
      if (inTxn && cnt > MAXC + 4) begin
        fail("done_timeout", cnt);
        inTxn = 1'b0;
        if (expQ.size() != 0) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    idle();
    mdIf.DXIR     = mkInst(5'd0, 5'd6);
    mdIf.dx_valid = 1'b1;
    #3;
    chk("init_stall", mdIf.stall, 0);
    chk("init_mult", mdIf.ctrl_MULT, 0);
    chk("init_busy", mdIf.busy, 0);
    chk("init_done", mdIf.md_done, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle();
    cyc();

    doMd(1'b0, 16, 1'b0);
`ifdef MULTDIV_PERF_EN
    chk("perf_stall", mdIf.perf_stall_cycles, 17);
`endif
    doMd(1'b1, 3, 1'b1);
    doMd(1'b0, 1000, 1'b0);
    for (int k = 0; k < 4; k++) bubble(k);
    doMd(1'b0, 5, 1'b0);
    doMd(1'b0, 5, 1'b0);
    doMd(1'b1, 1, 1'b0);
    doMd(1'b1, MAXC, 1'b0);
    doMd(1'b0, MAXC - 1, 1'b1);
    doMd(1'b1, MAXC + 1, 1'b0);
    resetMidOp();

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        bubble(int'($urandom_range(0, 3)));
      end else begin
        if ($urandom_range(0, 4) == 0)
          d = int'($urandom_range(MAXC - 2, MAXC + 5));
        else
          d = int'($urandom_range(1, 30));
        doMd(1'($urandom_range(0, 1)), d,
             1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 2)) begin
        mdIf.md_resultRDY = ($urandom_range(0, 3) == 0);
        cyc();
      end
      idle();
    end

    repeat (4) cyc();
    chk("queue_empty", expQ.size(), 0);
    chk("txn_closed", inTxn, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
